cpu_decoder_rom: RTL and testbench



---
 rtl/cpu_decoder_rom.sv | 78 +++++++
 tb/tb_cpu_decoder_rom.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_decoder_rom.sv
// Program ROM and opcode decoder for the 4-bit TD4-style CPU.
// Combinational outputs are also registered for one cycle as "_d" debug copies.
module cpu_decoder_rom (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] address,
    output logic [7:0] data,
    output logic [7:0] data_d,
    input  logic [3:0] opecode,
    input  logic       cflag,
    output logic [1:0] ds,
    output logic [3:0] load,
    output logic [1:0] ds_d,
    output logic [3:0] load_d
);

    logic [7:0] data_q;
    logic [1:0] ds_q;
    logic [3:0] load_q;

    // Fixed demo program: counts B from IN up to 15, then A from IN up to 15, then halts.
    always_comb begin
        // NOTE: default assigned before the case so unlisted selectors cannot infer a latch.
        data = 8'h00;
        case (address)
            4'd0:    data = 8'h20;  // IN A
            4'd1:    data = 8'h40;  // MOV B,A
            4'd2:    data = 8'h90;  // OUT B
            4'd3:    data = 8'h51;  // ADD B,1
            4'd4:    data = 8'hE2;  // JNC 2
            4'd5:    data = 8'hB5;  // OUT 5
            4'd6:    data = 8'h01;  // ADD A,1
            4'd7:    data = 8'hE6;  // JNC 6
            4'd8:    data = 8'hB0;  // OUT 0
            4'd9:    data = 8'hF9;  // JMP 9
            default: data = 8'h00;
        endcase
    end

    // Undefined opcodes fall through to ds=00 with no load, so the PC just increments.
    always_comb begin
        ds   = 2'b00;
        load = 4'b0000;
        case (opecode)
            4'b0000: begin ds = 2'b00; load = 4'b0001; end
            4'b0001: begin ds = 2'b01; load = 4'b0001; end
            4'b0010: begin ds = 2'b10; load = 4'b0001; end
            4'b0011: begin ds = 2'b11; load = 4'b0001; end
            4'b0100: begin ds = 2'b00; load = 4'b0010; end
            4'b0101: begin ds = 2'b01; load = 4'b0010; end
            4'b0110: begin ds = 2'b10; load = 4'b0010; end
            4'b0111: begin ds = 2'b11; load = 4'b0010; end
            4'b1001: begin ds = 2'b01; load = 4'b0100; end
            4'b1011: begin ds = 2'b11; load = 4'b0100; end
            4'b1110: begin ds = 2'b11; load = cflag ? 4'b1000 : 4'b0000; end
            4'b1111: begin ds = 2'b11; load = 4'b1000; end
            default: begin ds = 2'b00; load = 4'b0000; end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q <= 8'h00;
            ds_q   <= 2'b00;
            load_q <= 4'b0000;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            data_q <= data;
            ds_q   <= ds;
            load_q <= load;
        end
    end

    assign data_d = data_q;
    assign ds_d   = ds_q;
    assign load_d = load_q;

endmodule

// File: tb/tb_cpu_decoder_rom.sv
// Self-checking bench for cpu_decoder_rom: directed and random ROM/decode checks,
// registered-copy latency, asynchronous reset, and a small TD4 program run.
module tb_cpu_decoder_rom;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] address = 4'd0;
    logic [3:0] opecode = 4'd0;
    logic       cflag = 1'b0;
    logic [7:0] data, data_d;
    logic [1:0] ds, ds_d;
    logic [3:0] load, load_d;

    int checks = 0;
    int failures = 0;

    logic [7:0] rom_ref [16];
    logic [7:0] prev_data;
    logic [1:0] prev_ds;
    logic [3:0] prev_load;

    cpu_decoder_rom dut (
        .clk(clk), .rstn(rstn),
        .address(address), .data(data), .data_d(data_d),
        .opecode(opecode), .cflag(cflag),
        .ds(ds), .load(load), .ds_d(ds_d), .load_d(load_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decoder reference written from the ISA structure: opcodes 0xxx write A or B
    // (bit 2 picks the register, bits 1:0 pick the source), 10x1 write OUT, 111x jump.
    function automatic void ref_decode(input logic [3:0] op, input logic cf,
                                       output logic [1:0] eds, output logic [3:0] eld);
        eds = 2'b00;
        eld = 4'b0000;
        if (!op[3]) begin
            eds = op[1:0];
            eld = op[2] ? 4'b0010 : 4'b0001;
        end else if (op == 4'b1001 || op == 4'b1011) begin
            eds = op[1:0];
            eld = 4'b0100;
        end else if (op == 4'b1111) begin
            eds = 2'b11;
            eld = 4'b1000;
        end else if (op == 4'b1110) begin
            eds = 2'b11;
            eld = cf ? 4'b1000 : 4'b0000;
        end
    endfunction

    // One clock cycle: drive just after an edge, check combinational outputs and that
    // the registered copies still hold the previous cycle, then check them after the edge.
    task automatic cycle(input logic [3:0] a, input logic [3:0] op, input logic cf, input string tag);
        logic [1:0] eds;
        logic [3:0] eld;
        address = a;
        opecode = op;
        cflag   = cf;
        ref_decode(op, cf, eds, eld);
        #1;
        chk({tag, "_data"}, data, rom_ref[a]);
        chk({tag, "_ds"}, ds, eds);
        chk({tag, "_load"}, load, eld);
        chk({tag, "_onehot"}, ($countones(load) <= 1), 1);
        chk({tag, "_ds_d_hold"}, ds_d, prev_ds);
        chk({tag, "_load_d_hold"}, load_d, prev_load);
        chk({tag, "_data_d_hold"}, data_d, prev_data);
        @(posedge clk);
        #1;
        chk({tag, "_data_d"}, data_d, rom_ref[a]);
        chk({tag, "_ds_d"}, ds_d, eds);
        chk({tag, "_load_d"}, load_d, eld);
        prev_data = rom_ref[a];
        prev_ds   = eds;
        prev_load = eld;
    endtask

    initial begin
        int exp_out [9] = '{0, 10, 11, 12, 13, 14, 15, 5, 0};
        int out_seq [$];
        logic [3:0] ra, rb, rout, pc, src, im;
        logic [4:0] sum;
        logic       nc;

        for (int i = 0; i < 16; i++) rom_ref[i] = 8'h00;
        rom_ref[0] = 8'h20; rom_ref[1] = 8'h40; rom_ref[2] = 8'h90; rom_ref[3] = 8'h51;
        rom_ref[4] = 8'hE2; rom_ref[5] = 8'hB5; rom_ref[6] = 8'h01; rom_ref[7] = 8'hE6;
        rom_ref[8] = 8'hB0; rom_ref[9] = 8'hF9;

        // Reset state while rstn is held low across clock edges
        address = 4'd4;
        opecode = 4'b1111;
        #12;
        chk("rst_data_d", data_d, 8'h00);
        chk("rst_ds_d", ds_d, 2'b00);
        chk("rst_load_d", load_d, 4'b0000);
        chk("rst_comb_data", data, 8'hE2);
        chk("rst_comb_load", load, 4'b1000);
        prev_data = 8'h00; prev_ds = 2'b00; prev_load = 4'b0000;
        #1 rstn = 1'b1;
        #1;
        chk("rel_no_edge_ds_d", ds_d, 2'b00);
        @(posedge clk); #1;
        chk("first_edge_data_d", data_d, 8'hE2);
        chk("first_edge_load_d", load_d, 4'b1000);
        prev_data = 8'hE2; prev_ds = 2'b11; prev_load = 4'b1000;

        // ROM sweep
        for (int a = 0; a < 16; a++) cycle(4'(a), 4'(a), 1'b0, "rom_sweep");

        // Decode sweeps with both flag values, including JNC both ways
        for (int c = 0; c < 2; c++)
            for (int o = 0; o < 16; o++) cycle(4'(15 - o), 4'(o), c[0], "dec_sweep");

        // Registered path: 0011 then 1001 on consecutive cycles
        cycle(4'd0, 4'b0011, 1'b0, "reg_mova_im");
        cycle(4'd1, 4'b1001, 1'b0, "reg_out_b");

        // Random stimulus
        for (int i = 0; i < 150; i++)
            cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom), "rand");

        // Asynchronous reset mid-cycle, then resume
        cycle(4'd9, 4'b0101, 1'b0, "pre_rst");
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_data_d", data_d, 8'h00);
        chk("async_rst_ds_d", ds_d, 2'b00);
        chk("async_rst_load_d", load_d, 4'b0000);
        chk("async_rst_comb_ds", ds, 2'b01);
        chk("async_rst_comb_data", data, 8'hF9);
        @(posedge clk); #1;
        chk("rst_held_data_d", data_d, 8'h00);
        #2 rstn = 1'b1;
        prev_data = 8'h00; prev_ds = 2'b00; prev_load = 4'b0000;
        cycle(4'd5, 4'b1110, 1'b1, "post_rst");
        cycle(4'd7, 4'b0110, 1'b0, "post_rst2");

        // Program run: TD4 behavioural CPU fed by the DUT's ROM and decoder, IN = 1010
        ra = 4'd0; rb = 4'd0; rout = 4'd0; pc = 4'd0; nc = 1'b0;
        out_seq.push_back(0);
        for (int s = 0; s < 300; s++) begin
            address = pc;
            #1;
            opecode = data[7:4];
            im      = data[3:0];
            cflag   = nc;
            #1;
            case (ds)
                2'b00:   src = ra;
                2'b01:   src = rb;
                2'b10:   src = 4'b1010;
                default: src = 4'd0;
            endcase
            sum = {1'b0, src} + {1'b0, im};
            nc  = ~sum[4];
            if (load[0]) ra = sum[3:0];
            if (load[1]) rb = sum[3:0];
            if (load[2]) begin
                if (int'(sum[3:0]) != out_seq[$]) out_seq.push_back(int'(sum[3:0]));
                rout = sum[3:0];
            end
            pc = load[3] ? sum[3:0] : pc + 4'd1;
        end
        chk("sys_out_count", out_seq.size(), 9);
        for (int i = 0; i < 9 && i < out_seq.size(); i++)
            chk($sformatf("sys_out_%0d", i), out_seq[i], exp_out[i]);
        chk("sys_final_out", rout, 4'd0);
        chk("sys_pc_loop", pc, 4'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
